// File: rtl/pattern_loader.sv
// Byte-stream loader for the low/high pattern buffer pair: packs low/high byte
// pairs into consecutive field slots of one buffer, never the one the PAT is running from.
module pattern_loader #(
    parameter int d_width      = 8,
    parameter int bufp_width   = 3,
    parameter int fieldp_width = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_start,
    input  logic [bufp_width-1:0]            load_bufp,
    input  logic [fieldp_width-1:0]          load_last,
    input  logic                             load_abort,
    input  logic [bufp_width-1:0]            active_bufp,
    input  logic [d_width-1:0]               in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [bufp_width+fieldp_width-1:0] buf_fieldwp,
    output logic [d_width-1:0]               field_wdata,
    output logic                             field_write_en_low,
    output logic                             field_write_en_high,
    output logic                             busy,
    output logic                             done,
    output logic                             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [bufp_width-1:0]   bufp_q;
    logic [fieldp_width-1:0] last_q;
    logic [fieldp_width-1:0] cnt;

    logic loading;
    logic accept;
    logic start_ok;
    logic start_rej;
    logic final_byte;

    assign loading    = (state != IDLE);
    assign in_ready   = loading && (bufp_q != active_bufp) && !load_abort;
    assign accept     = in_valid && in_ready;
    assign start_ok   = (state == IDLE) && load_start && (load_bufp != active_bufp);
    assign start_rej  = (state == IDLE) && load_start && (load_bufp == active_bufp);
    assign final_byte = (state == HIGH) && (cnt == last_q);
    assign busy       = loading;

    // NOTE: next-state is assigned a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_ok)
                    state_next = LOW;
            end
            LOW: begin
                if (load_abort)
                    state_next = IDLE;
                else if (accept)
                    state_next = HIGH;
            end
            HIGH: begin
                if (load_abort)
                    state_next = IDLE;
                else if (accept)
                    state_next = final_byte ? IDLE : LOW;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Load parameters are only captured on an accepted start, so starts while busy leave them intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bufp_q <= '0;
            last_q <= '0;
            cnt    <= '0;
        end else if (start_ok) begin
            bufp_q <= load_bufp;
            last_q <= load_last;
            cnt    <= '0;
        end else if (accept && (state == HIGH) && !final_byte) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Write port: address/data hold their last value between strobes; strobes last one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_fieldwp         <= '0;
            field_wdata         <= '0;
            field_write_en_low  <= 1'b0;
            field_write_en_high <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
        end else begin
            field_write_en_low  <= 1'b0;
            field_write_en_high <= 1'b0;
            done                <= 1'b0;
            err                 <= start_rej;
            if (accept) begin
                buf_fieldwp         <= {bufp_q, cnt};
                field_wdata         <= in_data;
                field_write_en_low  <= (state == LOW);
                field_write_en_high <= (state == HIGH);
                done                <= final_byte;
            end
        end
    end

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (!reset)
        !(field_write_en_low && field_write_en_high));

    a_done_with_high: assert property (@(posedge clk) disable iff (!reset)
        done |-> field_write_en_high);

endmodule
